// File: rtl/ring_ni.sv
// ring_ni: ring NoC network interface; packetises host words into 3 flits and reassembles ejected flits into a receive FIFO.
module ring_ni #(
  parameter int DATAWID = 8,
  parameter int NODE_ID = 0,
  parameter int NUM_NODES = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [3:0]         tx_dest,
  input  logic [11:0]        tx_data,
  input  logic               net_stall,
  output logic [DATAWID-1:0] local_in,
  output logic               net_write,
  input  logic [DATAWID-1:0] local_out,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [11:0]        rx_data,
  output logic [7:0]         drop_cnt,
  output logic [7:0]         err_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  if (DATAWID != 8 || NUM_NODES > 16 || NODE_ID >= NUM_NODES || (1 << AW) != FIFO_DEPTH)
    $error("ring_ni: unsupported parameters");
  typedef enum logic [1:0] {IDLE, HEAD, BODY0, BODY1} tx_t;
  typedef enum logic [1:0] {WAIT_HEAD, WAIT_B0, WAIT_B1} rx_t;
  tx_t tx_state, tx_next;
  rx_t rx_state, rx_next;
  logic [3:0] dest_q, dest_n;
  logic [11:0] data_q, data_n;
  logic [7:0] flit_next;
  logic accept;
  assign tx_ready = !rst && (tx_state == IDLE || (tx_state == BODY1 && !net_stall));
  assign accept = tx_valid && tx_ready;
  assign net_write = local_in[7];
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      local_in <= '0;
    end else begin
      tx_state <= tx_next;
      local_in <= flit_next;
    end
    if (accept) begin
      dest_q <= tx_dest;
      data_q <= tx_data;
    end
  end
  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      IDLE:    tx_next = accept ? HEAD : IDLE;
      HEAD:    tx_next = net_stall ? HEAD : BODY0;
      BODY0:   tx_next = net_stall ? BODY0 : BODY1;
      default: tx_next = net_stall ? BODY1 : (accept ? HEAD : IDLE);
    endcase
  end
  // local_in is registered, so it is built from the state and payload being entered
  always_comb begin
    dest_n = accept ? tx_dest : dest_q;
    data_n = accept ? tx_data : data_q;
    flit_next = tx_next == HEAD  ? {2'b11, dest_n, 2'b00} :
                tx_next == BODY0 ? {2'b10, data_n[11:6]} :
                tx_next == BODY1 ? {2'b10, data_n[5:0]} : 8'h00;
  end
  logic fv, fh, dest_hit, err_ev, push, pop, full, wr_en, drop;
  logic [5:0] upper;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [11:0] mem [FIFO_DEPTH];
  assign fv = local_out[7];
  assign fh = local_out[6];
  assign dest_hit = local_out[5:2] == 4'(NODE_ID);
  always_ff @(posedge clk) begin
    if (rst) rx_state <= WAIT_HEAD;
    else rx_state <= rx_next;
    if (fv && !fh && rx_state == WAIT_B0) upper <= local_out[5:0];
  end
  always_comb begin
    rx_next = !fv ? rx_state :
              fh ? (dest_hit ? WAIT_B0 : WAIT_HEAD) :
              rx_state == WAIT_B0 ? WAIT_B1 : WAIT_HEAD;
  end
  // a head arriving mid-packet and failing the dest check still counts once
  always_comb begin
    err_ev = fv && (fh ? (rx_state != WAIT_HEAD || !dest_hit) : rx_state == WAIT_HEAD);
    push = fv && !fh && rx_state == WAIT_B1;
  end
  assign rx_valid = wr_ptr != rd_ptr;
  assign rx_data = rx_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign full = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
  assign pop = rx_valid && rx_ready;
  assign wr_en = push && (!full || pop);
  assign drop = push && full && !pop;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      if (err_ev && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {upper, local_out[5:0]};
endmodule

// File: tb/tb_ring_ni.sv
// tb_ring_ni: directed and random checks of ring_ni (NODE_ID=3) against a flit/word queue model.
module tb_ring_ni;
  logic clk = 0, rst = 1;
  logic tx_valid = 0, tx_ready, net_stall = 0, net_write, rx_valid, rx_ready = 0;
  logic [3:0] tx_dest = 0;
  logic [11:0] tx_data = 0, rx_data;
  logic [7:0] local_in, local_out = 0, drop_cnt, err_cnt;
  int checks = 0, errors = 0;
  logic [7:0] txq[$];
  logic [11:0] rxq[$];
  int rpos = 0, m_drop = 0, m_err = 0;
  logic [5:0] upper = 0;

  ring_ni #(.DATAWID(8), .NODE_ID(3), .NUM_NODES(12), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest(tx_dest),
    .tx_data(tx_data), .net_stall(net_stall), .local_in(local_in), .net_write(net_write),
    .local_out(local_out), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .drop_cnt(drop_cnt), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: check tx_ready, advance the model with the inputs present at the edge, check outputs after it
  task automatic tick();
    logic exp_rdy, err, pw;
    logic [7:0] f, d8;
    logic [11:0] d12;
    #1;
    exp_rdy = !rst && (txq.size() == 0 || (txq.size() == 1 && !net_stall));
    chk("tx_ready", tx_ready, exp_rdy);
    f = local_out;
    if (rst) begin
      txq.delete(); rxq.delete();
      rpos = 0; m_drop = 0; m_err = 0;
    end else begin
      if (!net_stall && txq.size() > 0) d8 = txq.pop_front();
      if (tx_valid && exp_rdy) begin
        txq.push_back({2'b11, tx_dest, 2'b00});
        txq.push_back({2'b10, tx_data[11:6]});
        txq.push_back({2'b10, tx_data[5:0]});
      end
      err = 0; pw = 0;
      if (f[7]) begin
        if (f[6]) begin
          err = rpos != 0;
          if (f[5:2] == 4'd3) rpos = 1;
          else begin err = 1; rpos = 0; end
        end else if (rpos == 0) err = 1;
        else if (rpos == 1) begin upper = f[5:0]; rpos = 2; end
        else begin pw = 1; rpos = 0; end
      end
      if (rxq.size() > 0 && rx_ready) d12 = rxq.pop_front();
      if (pw) begin
        if (rxq.size() < 4) rxq.push_back({upper, f[5:0]});
        else if (m_drop < 255) m_drop++;
      end
      if (err && m_err < 255) m_err++;
    end
    @(posedge clk); #1;
    d8 = txq.size() > 0 ? txq[0] : 8'h00;
    chk("local_in", local_in, d8);
    chk("net_write", net_write, d8[7]);
    chk("rx_valid", rx_valid, rxq.size() > 0);
    chk("rx_data", rx_data, rxq.size() > 0 ? rxq[0] : 12'h000);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("err_cnt", err_cnt, m_err);
  endtask

  task automatic rx_word(input logic [3:0] d, input logic [11:0] w);
    local_out = {2'b11, d, 2'b00}; tick();
    local_out = {2'b10, w[11:6]}; tick();
    local_out = {2'b10, w[5:0]}; tick();
    local_out = 0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_local_in", local_in, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    rst = 0;
    // TX basic
    tx_valid = 1; tx_dest = 5; tx_data = 12'hABC; tick();
    tx_valid = 0;
    chk("tx_head", local_in, 8'hD4);
    tick(); chk("tx_body0", local_in, 8'hAA);
    tick(); chk("tx_body1", local_in, 8'hBC);
    tick(); chk("tx_idle", local_in, 8'h00);
    // TX stall during body0, with a second word waiting
    tx_valid = 1; tick();
    tick(); chk("stall_b0", local_in, 8'hAA);
    net_stall = 1; tick(); chk("stall_hold1", local_in, 8'hAA);
    tick(); chk("stall_hold2", local_in, 8'hAA);
    net_stall = 0; tick(); chk("stall_b1", local_in, 8'hBC);
    tick(); chk("b2b_head", local_in, 8'hD4);
    tx_valid = 0; tick(); tick(); tick();
    // RX loopback
    local_out = 8'hCC; tick();
    local_out = 8'h00; tick();
    local_out = 8'h81; tick();
    local_out = 8'h85; tick();
    local_out = 8'h00;
    chk("lb_valid", rx_valid, 1'b1);
    chk("lb_data", rx_data, 12'h045);
    rx_ready = 1; tick(); rx_ready = 0;
    chk("lb_popped", rx_valid, 1'b0);
    // RX errors
    local_out = 8'hDC; tick();
    chk("err_misroute", err_cnt, 8'd1);
    local_out = 8'hCC; tick();
    rx_word(4'd3, 12'h045);
    chk("err_rehead", err_cnt, 8'd2);
    chk("err_word", rx_data, 12'h045);
    rx_ready = 1; tick(); rx_ready = 0;
    // FIFO full, then a word arriving on a pop cycle
    for (int i = 0; i < 5; i++) rx_word(4'd3, 12'h100 + 12'(i));
    chk("full_drop", drop_cnt, 8'd1);
    chk("full_head", rx_data, 12'h100);
    local_out = 8'hCC; tick();
    local_out = {2'b10, 6'h04}; tick();
    local_out = {2'b10, 6'h05}; rx_ready = 1; tick();
    local_out = 0;
    chk("full_pop_push", drop_cnt, 8'd1);
    for (int i = 0; i < 4; i++) tick();
    rx_ready = 0;
    // reset mid-packet
    tx_valid = 1; tx_dest = 2; tx_data = 12'h123; tick();
    tx_valid = 0; local_out = 8'hCC; tick();
    rst = 1; local_out = 0; tick();
    chk("mid_rst_local_in", local_in, 8'h00);
    chk("mid_rst_err", err_cnt, 8'd0);
    chk("mid_rst_drop", drop_cnt, 8'd0);
    rst = 0; local_out = 8'h81; tick();
    chk("mid_rst_rx_idle", err_cnt, 8'd1);
    local_out = 0;
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst = $urandom_range(0, 999) == 0;
      tx_valid = $urandom_range(0, 1);
      tx_dest = 4'($urandom);
      tx_data = 12'($urandom);
      net_stall = $urandom_range(0, 3) == 0;
      rx_ready = $urandom_range(0, 1);
      r = $urandom_range(0, 99);
      local_out = r < 25 ? {1'b0, 7'($urandom)} :
                  r < 55 ? {2'b11, ($urandom_range(0, 9) < 7) ? 4'd3 : 4'($urandom), 2'b00} :
                  {2'b10, 6'($urandom)};
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
